alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that computes an unsigned OP_W x OP_W -> DATA_W product by shift-and-add through the shared 32-bit ArithmeticLogicUnit.
- The ALU is used through its normal ports: A, B, FunSel, WF, ALUOut, FlagsOut. This block has no adder or shifter of its own.
- Sits beside the ALU in the datapath. When this block is Ready, the datapath owns the ALU.
- Start/Ready/Done handshake toward the control unit. Latches the final product and updates the ALU flag register once, at the end.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_mul_sequencer.sv | 116 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select codes, flag bit positions and the
// state encoding of the multiply sequencer that borrows the ALU.
package alu_pkg;

  localparam int ALU_W = 32;

  // Low nibble selects the operation; bit 4 selects 16-bit (0) or 32-bit (1).
  localparam logic [4:0] FS16_PASSA = 5'b00000;
  localparam logic [4:0] FS16_PASSB = 5'b00001;
  localparam logic [4:0] FS16_NOTA  = 5'b00010;
  localparam logic [4:0] FS16_NOTB  = 5'b00011;
  localparam logic [4:0] FS16_ADD   = 5'b00100;
  localparam logic [4:0] FS16_ADDC  = 5'b00101;
  localparam logic [4:0] FS16_SUB   = 5'b00110;
  localparam logic [4:0] FS16_AND   = 5'b00111;
  localparam logic [4:0] FS16_OR    = 5'b01000;
  localparam logic [4:0] FS16_XOR   = 5'b01001;
  localparam logic [4:0] FS16_NAND  = 5'b01010;
  localparam logic [4:0] FS16_LSL   = 5'b01011;
  localparam logic [4:0] FS16_LSR   = 5'b01100;
  localparam logic [4:0] FS16_ASR   = 5'b01101;
  localparam logic [4:0] FS16_CSL   = 5'b01110;
  localparam logic [4:0] FS16_CSR   = 5'b01111;
  localparam logic [4:0] FS_PASSA   = 5'b10000;
  localparam logic [4:0] FS_PASSB   = 5'b10001;
  localparam logic [4:0] FS_NOTA    = 5'b10010;
  localparam logic [4:0] FS_NOTB    = 5'b10011;
  localparam logic [4:0] FS_ADD     = 5'b10100;
  localparam logic [4:0] FS_ADDC    = 5'b10101;
  localparam logic [4:0] FS_SUB     = 5'b10110;
  localparam logic [4:0] FS_AND     = 5'b10111;
  localparam logic [4:0] FS_OR      = 5'b11000;
  localparam logic [4:0] FS_XOR     = 5'b11001;
  localparam logic [4:0] FS_NAND    = 5'b11010;
  localparam logic [4:0] FS_LSL     = 5'b11011;
  localparam logic [4:0] FS_LSR     = 5'b11100;
  localparam logic [4:0] FS_ASR     = 5'b11101;
  localparam logic [4:0] FS_CSL     = 5'b11110;
  localparam logic [4:0] FS_CSR     = 5'b11111;

  // Idle FunSel value driven when the sequencer does not own the ALU.
  localparam logic [4:0] FS_NONE    = 5'b00000;

  // Bit positions inside the ALU flag register.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    SHIFT = 3'd2,
    FLAGS = 3'd3,
    DONE  = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller. Owns no arithmetic of its own: every
// add and every multiplicand shift goes through the shared ALU. The flag
// register is written once, in FLAGS, with the Z/N of the final product.
module alu_mul_sequencer #(
  parameter int         DATA_W   = alu_pkg::ALU_W,
  parameter int         OP_W     = 16,
  parameter logic [4:0] FS_PASSA = alu_pkg::FS_PASSA,
  parameter logic [4:0] FS_ADD   = alu_pkg::FS_ADD,
  parameter logic [4:0] FS_LSL   = alu_pkg::FS_LSL
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [OP_W-1:0]   OpA,
  input  logic [OP_W-1:0]   OpB,
  output logic              Ready,
  output logic              Done,
  output logic [DATA_W-1:0] Product,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [4:0]        ALU_FunSel,
  output logic              ALU_WF,
  input  logic [DATA_W-1:0] ALU_Out
);

  import alu_pkg::*;

  mul_state_e        state, state_nxt;
  logic [DATA_W-1:0] prod;    // running partial product
  logic [DATA_W-1:0] mcand;   // multiplicand, shifted left once per SHIFT
  logic [OP_W-1:0]   mplier;  // remaining multiplier bits, LSB = current bit
  logic [OP_W-1:0]   mplier_shr;

  assign mplier_shr = mplier >> 1;

  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);

  // Next-state decode and Moore ALU drive from state and working registers.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    state_nxt  = state;
    ALU_A      = '0;
    ALU_B      = '0;
    ALU_FunSel = FS_NONE;
    ALU_WF     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (OpB == '0)   state_nxt = FLAGS;
          else if (OpB[0]) state_nxt = ADD;
          else             state_nxt = SHIFT;
        end
      end
      ADD: begin
        ALU_A      = prod;
        ALU_B      = mcand;
        ALU_FunSel = FS_ADD;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        ALU_A      = mcand;
        ALU_FunSel = FS_LSL;
        // Look one bit ahead: leave as soon as no set bits remain.
        if (mplier_shr == '0) state_nxt = FLAGS;
        else if (mplier[1])   state_nxt = ADD;
        else                  state_nxt = SHIFT;
      end
      FLAGS: begin
        ALU_A      = prod;
        ALU_FunSel = FS_PASSA;
        ALU_WF     = 1'b1;
        state_nxt  = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any operation straight back to IDLE.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Working registers load from operands or from the ALU result per step.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            prod   <= '0;
            mcand  <= {{(DATA_W-OP_W){1'b0}}, OpA};
            mplier <= OpB;
          end
        end
        ADD:   prod <= ALU_Out;
        SHIFT: begin
          mcand  <= ALU_Out;
          mplier <= mplier_shr;
        end
        FLAGS:   Product <= ALU_Out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a small ALU model closes the loop, and each
// operation is compared with plain multiplication and an expected FunSel
// schedule derived from the multiplier's bit pattern.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 16;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Start;
  logic [OP_W-1:0]   OpA, OpB;
  logic              Ready, Done, ALU_WF;
  logic [DATA_W-1:0] Product, ALU_A, ALU_B, ALU_Out;
  logic [4:0]        ALU_FunSel;
  logic [3:0]        flags = 4'b0000;

  int tests = 0;
  int fails = 0;

  logic [OP_W-1:0] ra, rb;
  int              done_seen;

  always #5 Clock = ~Clock;

  alu_mul_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
    .Ready(Ready), .Done(Done), .Product(Product),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ALU_Out(ALU_Out)
  );

  // ALU model: the three 32-bit functions the sequencer uses.
  always_comb begin
    case (ALU_FunSel)
      FS_PASSA: ALU_Out = ALU_A;
      FS_ADD:   ALU_Out = ALU_A + ALU_B;
      FS_LSL:   ALU_Out = ALU_A << 1;
      default:  ALU_Out = '0;
    endcase
  end

  // ALU flag register: Z/N follow the result when WF is set; C/O untouched.
  always @(posedge Clock) begin
    if (ALU_WF) begin
      flags[FLAG_Z] <= (ALU_Out == '0);
      flags[FLAG_N] <= ALU_Out[DATA_W-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic start_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    @(negedge Clock);
    check("ready_before_start", Ready, 1);
    Start = 1'b1;
    OpA   = a;
    OpB   = b;
  endtask

  // Follows one operation from the cycle after Start is sampled to the IDLE
  // cycle after DONE. With hold set, Start stays high and the operands are
  // retargeted to na/nb mid-operation; that request must start only once the
  // sequencer is back in IDLE.
  task automatic finish_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                           input bit hold, input logic [OP_W-1:0] na,
                           input logic [OP_W-1:0] nb);
    logic [4:0]  exp_seq[$];
    logic [31:0] exp_prod;
    int          msb, got, wf;
    bit          seq_ok;

    // One ADD for each set bit, one SHIFT per bit up to the top set bit,
    // then FLAGS and DONE.
    msb = -1;
    for (int i = 0; i < OP_W; i++) if (b[i]) msb = i;
    for (int i = 0; i <= msb; i++) begin
      if (b[i]) exp_seq.push_back(FS_ADD);
      exp_seq.push_back(FS_LSL);
    end
    exp_seq.push_back(FS_PASSA);
    exp_seq.push_back(FS_NONE);
    exp_prod = 32'(a) * 32'(b);

    got = 0; wf = 0; seq_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clock);
      if (i == 1 && !hold) Start = 1'b0;
      if (i == 2 && hold) begin
        OpA = na;
        OpB = nb;
      end
      if (ALU_WF) wf++;
      if (i <= exp_seq.size() && ALU_FunSel !== exp_seq[i-1]) seq_ok = 1'b0;
      if (Done) begin
        got = i;
        break;
      end
    end
    check("done_cycle", got, exp_seq.size());
    check("funsel_seq", seq_ok, 1);
    check("wf_count", wf, 1);
    check("product", Product, exp_prod);
    check("flag_z", flags[FLAG_Z], exp_prod == 0);
    check("flag_n", flags[FLAG_N], exp_prod[31]);
    @(negedge Clock);
    check("ready_after_done", Ready, 1);
    check("done_one_cycle", Done, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    OpA   = '0;
    OpB   = '0;
    repeat (2) @(negedge Clock);
    check("reset_ready", Ready, 1);
    check("reset_done", Done, 0);
    check("reset_product", Product, 0);
    check("reset_wf", ALU_WF, 0);
    check("reset_funsel", ALU_FunSel, FS_NONE);
    Reset = 1'b0;

    // Directed cases with their known latencies and products.
    start_op(16'd3, 16'd5);
    finish_op(16'd3, 16'd5, 1'b0, '0, '0);
    check("prod_3x5", Product, 32'h0000000F);

    start_op(16'h1234, 16'h0000);
    finish_op(16'h1234, 16'h0000, 1'b0, '0, '0);

    start_op(16'hFFFF, 16'hFFFF);
    finish_op(16'hFFFF, 16'hFFFF, 1'b0, '0, '0);
    check("prod_ffff_sq", Product, 32'hFFFE0001);

    start_op(16'd7, 16'h8000);
    finish_op(16'd7, 16'h8000, 1'b0, '0, '0);
    check("prod_7x8000", Product, 32'h00038000);

    // Start held high: the mid-operation request is ignored, and the held
    // request is taken in the IDLE cycle after DONE.
    start_op(16'd3, 16'd5);
    finish_op(16'd3, 16'd5, 1'b1, 16'd9, 16'd9);
    finish_op(16'd9, 16'd9, 1'b0, '0, '0);
    check("prod_held_9x9", Product, 32'd81);

    // Asynchronous reset in the middle of a SHIFT step.
    start_op(16'd7, 16'h8000);
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    check("pre_reset_in_shift", ALU_FunSel, FS_LSL);
    #2 Reset = 1'b1;
    #1;
    check("async_ready", Ready, 1);
    check("async_wf", ALU_WF, 0);
    check("async_alu_a", ALU_A, 0);
    check("async_alu_b", ALU_B, 0);
    check("async_funsel", ALU_FunSel, FS_NONE);
    check("async_product", Product, 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge Clock);
      if (Done) done_seen++;
    end
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      if (Done) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);
    check("product_after_abort", Product, 0);
    Start = 1'b0;
    start_op(16'd2, 16'd3);
    finish_op(16'd2, 16'd3, 1'b0, '0, '0);
    check("prod_2x3", Product, 32'd6);

    // Randomised operands, biased toward sparse and zero multipliers.
    for (int n = 0; n < 20; n++) begin
      ra = OP_W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = OP_W'(1) << $urandom_range(0, OP_W-1);
        default: rb = OP_W'($urandom);
      endcase
      start_op(ra, rb);
      finish_op(ra, rb, 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
